fmap_write_address_ctrl: RTL and testbench
==========================================

# fmap_write_address_ctrl

Write-side address controller for the convolution/max-pooling datapath. It accepts the stream of result pixels produced by the convolution engine, which is fed by the image read-address counters. It generates row-major write addresses, write enables and data for the output feature-map memory, and reports frame completion. Each frame is an n_r × n_c result map (26×26 for a 28×28 image with a 3×3 kernel).

## Interface
Parameters:
- counterWidth, 10, width of the row/column index outputs i, j
- addrWidth, 10, width of waddr; must satisfy 2^addrWidth ≥ n_r·n_c
- dataWidth, 16, pixel width (two's complement)
- n_c, 26, columns of the output map
- n_r, 26, rows of the output map

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset; asynchronous, active-low
- start  in  1  frame start request, sampled only in IDLE
- in_valid  in  1  result pixel present on in_data
- in_data  in  dataWidth  result pixel
- in_ready  out  1  controller accepts a pixel this cycle
- we  out  1  write enable to feature-map memory
- waddr  out  addrWidth  write address
- wdata  out  dataWidth  write data
- i  out  counterWidth  row index of the next pixel to accept
- j  out  counterWidth  column index of the next pixel to accept
- busy  out  1  frame in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse at frame completion

## Operation
- FSM states: IDLE, RUN, LAST, DONE.
- IDLE:
  - in_ready=0.
  - start=1 → RUN; clear i, j and the address accumulator.
- RUN:
  - in_ready=1.
  - Accept = in_valid & in_ready. Without an accept, nothing changes.
  - On accept: register we=1, waddr=accumulator, wdata=f(in_data). Then increment the accumulator and j.
  - j == n_c−1 → j=0, i=i+1.
  - Accepting pixel (n_r−1, n_c−1) → LAST; i, j wrap to 0.
- LAST:
  - in_ready=0; the final write is on the bus.
  - Next cycle → DONE.
- DONE:
  - done=1 for exactly one cycle, then → IDLE.
- Address is a running accumulator (+1 per accept), never a multiplier. waddr = i·n_c + j of the accepted pixel, range 0 … n_r·n_c−1.
- we is low in every cycle without a preceding accept. waddr and wdata hold their last values while we=0.
- start outside IDLE is ignored; it is not queued.
- in_valid outside RUN is ignored; the data is not consumed.
- Reset asserted at any point, including mid-frame:
  - state=IDLE.
  - i, j, waddr, wdata, accumulator = 0.
  - we, in_ready, busy, done = 0.
  - No partial write completes after reset.

## Timing
- Reset values: every output 0.
- start sampled at edge T → state RUN, in_ready=1 from T+1.
- Accept at edge A → we=1 with matching waddr/wdata during A+1. Latency 1 cycle, throughput 1 pixel/cycle.
- Last accept at edge L:
  - L+1: state LAST, we=1, waddr=n_r·n_c−1, in_ready=0.
  - L+2: done=1, busy=1.
  - L+3: busy=0, start accepted again.
- Minimum frame time with continuous in_valid: 1 + n_r·n_c + 2 cycles from start to IDLE.
- Simultaneous start and done: impossible, since start is sampled only in IDLE. A start held high through DONE begins a new frame at the first IDLE cycle.

## Configuration
- Macro FMAP_WRITE_RELU_EN.
- Defined: wdata = (in_data[dataWidth−1]==1) ? 0 : in_data, i.e. ReLU applied on write.
- Undefined: wdata = in_data unchanged.
- Either way the latency is unchanged and the function stays in the registered path.

## Test plan
- Continuous frame:
  - Stimulus: start, then in_valid=1 with data = pixel index for 676 cycles.
  - Required: 676 writes with waddr=wdata=0…675 in order; done pulses at L+2; i, j return to 0.
- Gapped input:
  - Stimulus: in_valid toggling 1,0,0,1,… over a full frame.
  - Required: same address sequence, no duplicate or skipped address; we=0 in every gap cycle.
- Row wrap:
  - Stimulus: accept pixels 24…27.
  - Required: (i,j) go (0,24)→(0,25)→(1,0)→(1,1); waddr 24, 25, 26, 27.
- Start while busy:
  - Stimulus: pulse start at pixel 100.
  - Required: no effect, frame completes normally.
  - Stimulus: start held high through DONE.
  - Required: the second frame starts in IDLE+0 and begins at waddr=0.
- Reset mid-frame:
  - Stimulus: rst low at pixel 300, asynchronously between edges.
  - Required: outputs 0 immediately, no we afterwards; a fresh frame after release starts at waddr=0.
- ReLU:
  - Stimulus: in_data=0xFFF6 (−10), then 0x0005.
  - Required with FMAP_WRITE_RELU_EN: wdata 0x0000, 0x0005.
  - Required without: wdata 0xFFF6, 0x0005.

Source files
------------

// File: rtl/fmap_write_address_ctrl.sv
// fmap_write_address_ctrl: row-major write address/enable/data generator for the output feature map.
// Optional ReLU on write when FMAP_WRITE_RELU_EN is defined.
module fmap_write_address_ctrl #(
   parameter int counterWidth = 10,
   parameter int addrWidth    = 10,
   parameter int dataWidth    = 16,
   parameter int n_c          = 26,
   parameter int n_r          = 26
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    in_valid,
   input  logic [dataWidth-1:0]    in_data,
   output logic                    in_ready,
   output logic                    we,
   output logic [addrWidth-1:0]    waddr,
   output logic [dataWidth-1:0]    wdata,
   output logic [counterWidth-1:0] i,
   output logic [counterWidth-1:0] j,
   output logic                    busy,
   output logic                    done
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] LAST = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]           state;
   logic [addrWidth-1:0] acc;
   logic [dataWidth-1:0] wval;
   logic                 accept, last_col, last_row;

   assign in_ready = state == RUN;
   assign busy     = state != IDLE;
   assign done     = state == DONE;
   assign accept   = in_valid & in_ready;
   assign last_col = j == counterWidth'(n_c - 1);
   assign last_row = i == counterWidth'(n_r - 1);
`ifdef FMAP_WRITE_RELU_EN
   assign wval = in_data[dataWidth-1] ? '0 : in_data;
`else
   assign wval = in_data;
`endif

   // acc tracks i*n_c + j incrementally, so no multiplier is needed
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         acc   <= '0;
         i     <= '0;
         j     <= '0;
         we    <= 1'b0;
         waddr <= '0;
         wdata <= '0;
      end else begin
         we <= accept;
         unique case (state)
            IDLE: if (start) begin
               state <= RUN;
               acc   <= '0;
               i     <= '0;
               j     <= '0;
            end
            RUN: if (accept) begin
               waddr <= acc;
               wdata <= wval;
               acc   <= acc + addrWidth'(1);
               j     <= last_col ? '0 : j + counterWidth'(1);
               if (last_col) i <= last_row ? '0 : i + counterWidth'(1);
               if (last_col && last_row) state <= LAST;
            end
            LAST: state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fmap_write_address_ctrl.sv
// tb_fmap_write_address_ctrl: directed vector table plus hand-written frame sequences.
module tb_fmap_write_address_ctrl;
   logic        clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready, we, busy, done;
   logic [9:0]  waddr, i, j;
   logic [15:0] wdata;
   int checks = 0, failures = 0;

   fmap_write_address_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
      .i(i), .j(j), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        start, valid;
      logic [15:0] data;
      logic        rdy, we;
      logic [9:0]  waddr;
      logic [15:0] wdata;
      logic [9:0]  i, j;
      logic        busy, done;
   } vec_t;
   vec_t tbl [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // feed pixels from..upto-1, each pixel's data equal to its index
   task automatic feed(input bit gap, input bit hold, input int from, input int upto);
      int n = from;
      int cyc = 0;
      bit v;
      while (n < upto && cyc < 3000) begin
         v = gap ? (cyc % 3 == 0) : 1'b1;
         in_valid = v;
         in_data = v ? 16'(n) : 16'hDEAD;
         start = hold || (!gap && n == 100);
         step;
         cyc++;
         if (v) begin
            chk("wr_we", we, 1);
            chk("wr_addr", waddr, n);
            chk("wr_data", wdata, n);
            n++;
            chk("next_ij", {i, j}, ((n % 676) / 26) * 1024 + n % 26);
         end else
            chk("gap_we", we, 0);
      end
      if (n < upto) chk("feed_timeout", n, upto);
   endtask

   task automatic end_frame;
      chk("last_rdy", in_ready, 0);
      chk("last_busy", busy, 1);
      chk("last_done", done, 0);
      step;
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 1);
      chk("done_we", we, 0);
      chk("done_ij", {i, j}, 0);
      step;
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
   endtask

   task automatic mid_reset;
      #3 rst = 1'b0;
      #1 chk("rst_async_outs", {in_ready, we, waddr, wdata, i, j, busy, done}, 0);
      in_valid = 1'b1;
      step;
      chk("rst_no_we", we, 0);
      step;
      chk("rst_no_we2", {we, busy, waddr}, 0);
      rst = 1'b1;
      in_valid = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 10'd0, 16'h0000, 10'd0, 10'd0, 1'b1, 1'b0};
`ifdef FMAP_WRITE_RELU_EN
      tbl[1] = '{1'b0, 1'b1, 16'hFFF6, 1'b1, 1'b1, 10'd0, 16'h0000, 10'd0, 10'd1, 1'b1, 1'b0};
`else
      tbl[1] = '{1'b0, 1'b1, 16'hFFF6, 1'b1, 1'b1, 10'd0, 16'hFFF6, 10'd0, 10'd1, 1'b1, 1'b0};
`endif
      tbl[2] = '{1'b0, 1'b1, 16'h0005, 1'b1, 1'b1, 10'd1, 16'h0005, 10'd0, 10'd2, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 16'h7777, 1'b1, 1'b0, 10'd1, 16'h0005, 10'd0, 10'd2, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 10'd2, 16'h1234, 10'd0, 10'd3, 1'b1, 1'b0};

      #12 chk("reset_outs", {in_ready, we, waddr, wdata, i, j, busy, done}, 0);
      step;
      step;
      rst = 1'b1;

      for (int k = 0; k < 5; k++) begin
         start = tbl[k].start;
         in_valid = tbl[k].valid;
         in_data = tbl[k].data;
         step;
         chk("vec_rdy", in_ready, tbl[k].rdy);
         chk("vec_we", we, tbl[k].we);
         chk("vec_waddr", waddr, tbl[k].waddr);
         chk("vec_wdata", wdata, tbl[k].wdata);
         chk("vec_ij", {i, j}, {tbl[k].i, tbl[k].j});
         chk("vec_busy_done", {busy, done}, {tbl[k].busy, tbl[k].done});
      end
      mid_reset;

      start = 1'b1;
      step;
      chk("run_rdy", {in_ready, busy}, 2'b11);
      feed(1'b0, 1'b0, 0, 676);
      end_frame;

      start = 1'b1;
      in_valid = 1'b0;
      step;
      chk("run_rdy_gap", {in_ready, busy}, 2'b11);
      feed(1'b1, 1'b1, 0, 676);
      end_frame;
      step;
      chk("restart_held", {in_ready, busy}, 2'b11);
      start = 1'b0;
      feed(1'b0, 1'b0, 0, 300);
      mid_reset;

      start = 1'b1;
      step;
      chk("fresh_rdy", in_ready, 1);
      start = 1'b0;
      feed(1'b0, 1'b0, 0, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
